// File: rtl/wb_regfile_pkg.sv
// ============================================================================
// wb_regfile_pkg : shared widths, control-bit indices and types for the
//                  write-back stage / register file.  Rev 1.0
// ============================================================================
`default_nettype none

package wb_regfile_pkg;

  localparam int WIDTH           = 32;
  localparam int R_WIDTH         = 5;
  localparam int WB_CTRL_WIDTH   = 2;
  localparam int DEPTH           = 1 << R_WIDTH;
  localparam int CNT_WIDTH       = 32;

  localparam int WB_REGWRITE_BIT = 0;
  localparam int WB_MEMTOREG_BIT = 1;

  typedef logic [WIDTH-1:0]         word_t;
  typedef logic [R_WIDTH-1:0]       reg_addr_t;
  typedef logic [WB_CTRL_WIDTH-1:0] wb_ctrl_t;
  typedef logic [CNT_WIDTH-1:0]     count_t;

  // A write to r0 never commits, so it is not an effective write at all.
  function automatic logic wb_write_en(input wb_ctrl_t ctrl, input reg_addr_t rd);
    return ctrl[WB_REGWRITE_BIT] && (rd != '0);
  endfunction

  function automatic word_t wb_select(input wb_ctrl_t ctrl, input word_t load_data,
                                      input word_t alu_result);
    return ctrl[WB_MEMTOREG_BIT] ? load_data : alu_result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_regfile_if.sv
// ============================================================================
// wb_regfile_if : MEM/WB inputs, ID-stage read ports and debug outputs of the
//                 register file, bundled with master/slave modports.  Rev 1.0
// ============================================================================
`default_nettype none

interface wb_regfile_if;
  import wb_regfile_pkg::*;

  wb_ctrl_t  WB_ctrl_i;
  word_t     read_data_i;
  word_t     result_i;
  reg_addr_t rd_i;
  reg_addr_t rs_addr_i;
  reg_addr_t rt_addr_i;

  word_t     rs_data_o;
  word_t     rt_data_o;
  word_t     wb_data_o;
  logic      wb_we_o;
  count_t    wr_count_o;

  modport master (
    output WB_ctrl_i, read_data_i, result_i, rd_i, rs_addr_i, rt_addr_i,
    input  rs_data_o, rt_data_o, wb_data_o, wb_we_o, wr_count_o
  );

  modport slave (
    input  WB_ctrl_i, read_data_i, result_i, rd_i, rs_addr_i, rt_addr_i,
    output rs_data_o, rt_data_o, wb_data_o, wb_we_o, wr_count_o
  );

endinterface

`default_nettype wire

// File: rtl/wb_regfile_read_port.sv
// ============================================================================
// wb_read_port : one combinational register-file read port with r0 forcing.
//                Optional write-through under REGFILE_BYPASS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module wb_read_port
  import wb_regfile_pkg::*;
(
  input  reg_addr_t addr_i,
  input  word_t     regs_i [DEPTH],
`ifdef REGFILE_BYPASS_EN
  input  logic      wb_we_i,
  input  reg_addr_t rd_i,
  input  word_t     wb_data_i,
`endif
  output word_t     data_o
);

  word_t w_data;

  always_comb begin
    w_data = regs_i[addr_i];
`ifdef REGFILE_BYPASS_EN
    // wb_we_i already excludes r0, so the zero force below stays authoritative.
    if (wb_we_i && (addr_i == rd_i)) begin
      w_data = wb_data_i;
    end
`endif
    if (addr_i == '0) begin
      w_data = '0;
    end
  end

  assign data_o = w_data;

endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
// ============================================================================
// wb_regfile : MIPS write-back mux, 32-entry register file and committed-write
//              counter.  Optional macro: REGFILE_BYPASS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_n_i,
  wb_regfile_if.slave   bus
);

  word_t  w_wb_data;
  logic   w_wb_we;
  word_t  r_regs [DEPTH];
  count_t r_wr_count;

  assign w_wb_data = wb_select(bus.WB_ctrl_i, bus.read_data_i, bus.result_i);
  assign w_wb_we   = wb_write_en(bus.WB_ctrl_i, bus.rd_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_we) begin
      r_regs[bus.rd_i] <= w_wb_data;
    end
  end

  // Free-running wrap past all-ones is intentional; no saturation.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_count <= '0;
    end else if (w_wb_we) begin
      r_wr_count <= r_wr_count + count_t'(1);
    end
  end

  wb_read_port u_rs_port (
    .addr_i    (bus.rs_addr_i),
    .regs_i    (r_regs),
`ifdef REGFILE_BYPASS_EN
    .wb_we_i   (w_wb_we),
    .rd_i      (bus.rd_i),
    .wb_data_i (w_wb_data),
`endif
    .data_o    (bus.rs_data_o)
  );

  wb_read_port u_rt_port (
    .addr_i    (bus.rt_addr_i),
    .regs_i    (r_regs),
`ifdef REGFILE_BYPASS_EN
    .wb_we_i   (w_wb_we),
    .rd_i      (bus.rd_i),
    .wb_data_i (w_wb_data),
`endif
    .data_o    (bus.rt_data_o)
  );

  assign bus.wb_data_o  = w_wb_data;
  assign bus.wb_we_o    = w_wb_we;
  assign bus.wr_count_o = r_wr_count;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// tb_wb_regfile : randomized scoreboard bench for wb_regfile against an
//                 array-based reference model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_regfile;

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] wb;
    logic        we;
    logic [31:0] cnt;
    int          tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];
  logic [31:0] mdl [32];
  logic [31:0] mdl_cnt;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] rd, input logic [31:0] wbv);
    if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (we && a == rd) return wbv;
`endif
    return mdl[a];
  endfunction

  task automatic chk(input string nm, input int tag, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s tag=%0d got=%h want=%h", nm, tag, act, want);
    end
  endtask

  // Monitor: every queued expectation is compared shortly after the driver applies inputs.
  initial begin
    exp_t e;
    forever begin
      wait (exp_q.size() != 0);
      #1;
      e = exp_q.pop_front();
      chk("rs_data", e.tag, bus.rs_data_o, e.rs);
      chk("rt_data", e.tag, bus.rt_data_o, e.rt);
      chk("wb_data", e.tag, bus.wb_data_o, e.wb);
      chk("wb_we",   e.tag, {31'd0, bus.wb_we_o}, {31'd0, e.we});
      chk("count",   e.tag, bus.wr_count_o, e.cnt);
    end
  end

  task automatic cycle(input logic rstn, input logic [1:0] ctrl, input logic [31:0] rdat,
                       input logic [31:0] res, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input int tag);
    exp_t        e;
    logic [31:0] wbv;
    logic        we;
    @(negedge clk);
    rst_n           = rstn;
    bus.WB_ctrl_i   = ctrl;
    bus.read_data_i = rdat;
    bus.result_i    = res;
    bus.rd_i        = rd;
    bus.rs_addr_i   = rs;
    bus.rt_addr_i   = rt;
    if (!rstn) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      mdl_cnt = 32'd0;
    end
    wbv   = ctrl[1] ? rdat : res;
    we    = ctrl[0] && (rd != 5'd0);
    e.rs  = ref_read(rs, we, rd, wbv);
    e.rt  = ref_read(rt, we, rd, wbv);
    e.wb  = wbv;
    e.we  = we;
    e.cnt = mdl_cnt;
    e.tag = tag;
    exp_q.push_back(e);
    if (rstn && we) begin
      mdl[rd] = wbv;
      mdl_cnt = mdl_cnt + 32'd1;
    end
  endtask

  task automatic preload_count(input logic [31:0] v);
    @(negedge clk);
    bus.WB_ctrl_i = 2'b00;
    force dut.r_wr_count = v;
    #1;
    release dut.r_wr_count;
    mdl_cnt = v;
  endtask

  initial begin
    logic [4:0] rd_r;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    mdl_cnt         = 32'd0;
    bus.WB_ctrl_i   = 2'b00;
    bus.read_data_i = 32'd0;
    bus.result_i    = 32'd0;
    bus.rd_i        = 5'd0;
    bus.rs_addr_i   = 5'd0;
    bus.rt_addr_i   = 5'd0;

    // Reset held: sweep every address on both ports.
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'(i), 5'(31 - i), 100 + i);
    end
    // A write presented while reset is held must be lost.
    cycle(1'b0, 2'b01, 32'd0, 32'h0000_0055, 5'd5, 5'd4, 5'd6, 140);

    cycle(1'b1, 2'b01, 32'd0, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd0, 200);
    cycle(1'b1, 2'b11, 32'h1234_5678, 32'd0, 5'd0, 5'd5, 5'd0, 201);
    cycle(1'b1, 2'b00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd5, 202);
    cycle(1'b1, 2'b01, 32'd0, 32'hA5A5_A5A5, 5'd7, 5'd7, 5'd7, 203);
    cycle(1'b1, 2'b00, 32'd0, 32'd0, 5'd0, 5'd7, 5'd7, 204);
    cycle(1'b1, 2'b11, 32'hCAFE_F00D, 32'h1111_1111, 5'd9, 5'd9, 5'd7, 205);
    cycle(1'b1, 2'b10, 32'h2222_2222, 32'h3333_3333, 5'd9, 5'd9, 5'd5, 206);

    for (int n = 0; n < 400; n++) begin
      rd_r = 5'($urandom);
      cycle(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom, rd_r,
            ($urandom_range(0, 3) == 0) ? rd_r : 5'($urandom),
            ($urandom_range(0, 3) == 0) ? rd_r : 5'($urandom), 1000 + n);
    end

    // Counter wrap from all-ones.
    preload_count(32'hFFFF_FFFF);
    cycle(1'b1, 2'b00, 32'd0, 32'd0, 5'd0, 5'd3, 5'd0, 300);
    cycle(1'b1, 2'b01, 32'd0, 32'h0BAD_CAFE, 5'd3, 5'd3, 5'd0, 301);
    cycle(1'b1, 2'b00, 32'd0, 32'd0, 5'd0, 5'd3, 5'd3, 302);

    // Mid-stream asynchronous reset after filling r1..r4.
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 2'b01, 32'd0, 32'h4000_0000 + 32'(i), 5'(i), 5'(i), 5'd1, 400 + i);
    end
    cycle(1'b1, 2'b00, 32'd0, 32'd0, 5'd0, 5'd1, 5'd4, 405);
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'd1, 5'd4, 406);
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'd2, 5'd3, 407);
    cycle(1'b1, 2'b01, 32'd0, 32'h7777_7777, 5'd2, 5'd2, 5'd1, 408);
    cycle(1'b1, 2'b00, 32'd0, 32'd0, 5'd0, 5'd2, 5'd1, 409);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and general-purpose register file for the pipelined MIPS core. It consumes the MEM/WB pipeline register outputs, selects the write-back value (load data or ALU result), and commits it to a 32-entry register array on the rising clock edge. Two combinational read ports feed the ID stage. A committed-write counter supports debug and performance checks.

## Interface
- `WIDTH`, 32: datapath and register width.
- `R_WIDTH`, 5: register address width; depth is 2^R_WIDTH.
- `WB_CTRL_WIDTH`, 2: write-back control width; bit0 = RegWrite, bit1 = MemtoReg.
- `clk_i`  in  1: core clock; array and counter update on the rising edge.
- `rst_n_i`  in  1: reset, asynchronous, active-low.
- `WB_ctrl_i`  in  WB_CTRL_WIDTH: write-back control from MEM/WB.
- `read_data_i`  in  WIDTH: load data from MEM/WB.
- `result_i`  in  WIDTH: ALU result from MEM/WB.
- `rd_i`  in  R_WIDTH: destination register from MEM/WB.
- `rs_addr_i`  in  R_WIDTH: read port A address.
- `rt_addr_i`  in  R_WIDTH: read port B address.
- `rs_data_o`  out  WIDTH: read port A data.
- `rt_data_o`  out  WIDTH: read port B data.
- `wb_data_o`  out  WIDTH: selected write-back value; combinational, used for forwarding.
- `wb_we_o`  out  1: effective write enable; combinational, equals RegWrite && rd_i != 0.
- `wr_count_o`  out  32: number of committed register writes.

## Operation
- `wb_data_o` is `read_data_i` when MemtoReg = 1, and `result_i` when MemtoReg = 0.
- On the rising edge with `wb_we_o` = 1, write `regs[rd_i]` <= `wb_data_o`.
- `wb_we_o` = 0 leaves the array unchanged.
- Register 0 is hardwired to zero:
  - A write to rd = 0 is dropped and not counted.
  - A read of address 0 always returns 0.
- `wr_count_o` increments by 1 on each committed write.
  - It wraps from 0xFFFF_FFFF to 0 with no saturation and no flag.
- Read ports are combinational from the array and are independent.
  - Both ports may address the same register.
- Reset (async assert): all array entries are 0 and `wr_count_o` is 0.
  - `rs_data_o`, `rt_data_o` and `wb_data_o` follow from zeroed state and inputs.
  - A reset asserted during a write edge wins; the write is lost.
- Deassertion is synchronised externally. The first rising edge after deassertion may commit a write.
- X on `WB_ctrl_i` bit0 during reset is ignored.

## Timing
- MEM/WB outputs update on the falling edge. The write commits on the following rising edge, half a cycle later.
- Write latency: the new value is visible on the read ports immediately after the committing rising edge.
- Same-cycle read of a register being written (without the bypass macro): the port returns the old value until the edge.
- `wb_data_o` and `wb_we_o` have zero latency from the inputs.
- The counter updates on the same edge as the array.

## Configuration
- `REGFILE_BYPASS_EN` defined: a read port returns `wb_data_o` when all of the following hold:
  - `wb_we_o` = 1;
  - the port address equals `rd_i`;
  - the address is non-zero.
  - This gives write-through within the same cycle, before the edge.
- Macro undefined: read ports return array contents only.
- Counter and writes are identical in both builds.

## Structure
- The shared package/defines file holds:
  - `WIDTH`, `R_WIDTH` and `WB_CTRL_WIDTH`;
  - the bit indices `WB_REGWRITE_BIT` = 0 and `WB_MEMTOREG_BIT` = 1.
- One sub-module, `wb_read_port`, instantiated twice. It takes an address and returns array data, with zero forcing and the optional bypass mux.
- The write-back mux and the counter live in the top module.

## Test plan
- Reset then read all 32 addresses: both ports return 0 and `wr_count_o` = 0.
- RegWrite = 1, MemtoReg = 0, result = 0xDEAD_BEEF, rd = 5; after the rising edge, rs = 5 reads 0xDEAD_BEEF and count = 1.
- RegWrite = 1, MemtoReg = 1, read_data = 0x1234_5678, rd = 0:
  - `wb_we_o` = 0;
  - after the edge, address 0 reads 0;
  - count is unchanged.
- rd = 7, result = 0xA5A5_A5A5, rs = rt = 7 in the same cycle before the edge:
  - with `REGFILE_BYPASS_EN`, both ports read 0xA5A5_A5A5;
  - without it, both read the old value, then 0xA5A5_A5A5 after the edge.
- Preload the counter with 0xFFFF_FFFF via a forced sequence (or 2^32 writes in the formal bench). One more write to rd = 3 gives count = 0.
- Assert `rst_n_i` mid-stream after writing r1..r4: all outputs return to 0 asynchronously, before the next edge.
